// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the elastic pipeline stage: MEM->WB bundle layout,
// occupancy encodings and the skid-buffer state encoding.
package pipe_stage_skid_pkg;

  // MEM->WB bundle field offsets and widths
  localparam int MEM_WB_WE_LSB        = 0;
  localparam int MEM_WB_WE_W          = 1;
  localparam int MEM_WB_REG_SRC_LSB   = 1;
  localparam int MEM_WB_REG_SRC_W     = 2;
  localparam int MEM_WB_WR_ADDR_LSB   = 3;
  localparam int MEM_WB_WR_ADDR_W     = 5;
  localparam int MEM_WB_ALU_OUT_LSB   = 8;
  localparam int MEM_WB_ALU_OUT_W     = 32;
  localparam int MEM_WB_READ_DATA_LSB = 40;
  localparam int MEM_WB_READ_DATA_W   = 32;
  localparam int MEM_WB_W             = 72;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  typedef struct packed {
    logic [MEM_WB_READ_DATA_W-1:0] read_data;
    logic [MEM_WB_ALU_OUT_W-1:0]   alu_out;
    logic [MEM_WB_WR_ADDR_W-1:0]   wr_addr;
    logic [MEM_WB_REG_SRC_W-1:0]   reg_src;
    logic                          we;
  } mem_wb_t;

  // Encoded as {main_v, skid_v}; {0,1} is unreachable
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b10,
    SKID_FULL  = 2'b11
  } skid_state_e;

  function automatic logic [1:0] occ_of(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_skid_core.sv
// Generic two-entry valid/ready skid buffer with synchronous flush.
// Payload is opaque here; in_ready depends only on registered state and rst.
module pipe_skid_core
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W = MEM_WB_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              main_v,
  output logic              skid_v
);

  skid_state_e       state;
  skid_state_e       state_n;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_d;
  logic              accept;
  logic              emit;
  logic              load_main;
  logic              load_skid;
  logic              shift;

  assign main_v    = (state == SKID_ONE) || (state == SKID_FULL);
  assign skid_v    = (state == SKID_FULL);
  assign in_ready  = !skid_v && !rst;
  assign out_valid = main_v;
  assign out_data  = main_d;
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  always_comb begin
    state_n   = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    shift     = 1'b0;
    case (state)
      SKID_EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          state_n   = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (emit && accept) begin
          load_main = 1'b1;
        end else if (emit) begin
          state_n = SKID_EMPTY;
        end else if (accept) begin
          load_skid = 1'b1;
          state_n   = SKID_FULL;
        end
      end
      SKID_FULL: begin
        // in_ready is low here, so only the skid entry can advance
        if (emit) begin
          shift   = 1'b1;
          state_n = SKID_ONE;
        end
      end
      default: state_n = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= SKID_EMPTY;
      main_d <= '0;
      skid_d <= '0;
    end else if (flush) begin
      state  <= SKID_EMPTY;
      main_d <= '0;
      skid_d <= '0;
    end else begin
      state <= state_n;
      if (load_main) begin
        main_d <= in_data;
      end else if (shift) begin
        main_d <= skid_d;
      end
      if (load_skid) begin
        skid_d <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register: skid buffer or single register, with
// write-enable gating so a bubble can never commit, plus occupancy output.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W  = MEM_WB_W,
  parameter int WE_LSB  = MEM_WB_WE_LSB,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  logic              main_v;
  logic              skid_v;
  logic [DATA_W-1:0] held_d;

  generate
    if (SKID_EN) begin : g_skid
      pipe_skid_core #(
        .DATA_W (DATA_W)
      ) u_core (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (main_v),
        .out_ready (out_ready),
        .out_data  (held_d),
        .main_v    (),
        .skid_v    (skid_v)
      );
    end else begin : g_single
      logic              reg_v;
      logic [DATA_W-1:0] reg_d;

      // Combinational ready: a slot frees up in the same cycle it drains
      assign in_ready = (!reg_v || out_ready) && !rst;
      assign main_v   = reg_v;
      assign held_d   = reg_d;
      assign skid_v   = 1'b0;

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          reg_v <= 1'b0;
          reg_d <= '0;
        end else if (in_valid && in_ready) begin
          reg_v <= 1'b1;
          reg_d <= in_data;
        end else if (out_ready) begin
          reg_v <= 1'b0;
        end
      end
    end
  endgenerate

  assign out_valid = main_v;
  assign occ       = occ_of(main_v, skid_v);

  always_comb begin
    out_data         = held_d;
    out_data[WE_LSB] = held_d[WE_LSB] & main_v;
  end

  // Downstream relies on a stalled beat not changing underneath it
  assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

endmodule
